// File: rtl/sram_bus_bridge_pkg.sv
// Shared types and constants for the instruction/data SRAM to single-bus bridge.
// Holds the FSM state encoding, the bus widths and the default physical address mask.
package sram_bus_bridge_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Folds kseg0/kseg1 virtual addresses onto the physical map.
    localparam logic [ADDR_W-1:0] DEFAULT_ADDR_MASK = 32'h1FFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_ADDR = 3'd1,
        ST_D_DATA = 3'd2,
        ST_I_ADDR = 3'd3,
        ST_I_DATA = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

endpackage

// File: rtl/sram_bus_bridge.sv
// Serialises the pipeline's data and instruction SRAM requests onto one shared bus.
// The data access always goes first, and the pipeline is stalled until every captured access has finished.
module sram_bus_bridge
    import sram_bus_bridge_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_MASK = DEFAULT_ADDR_MASK
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_en,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_en,
    input  logic [STRB_W-1:0] data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              cpu_stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [STRB_W-1:0] bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output state_t            dbg_state
);

    // Bus handshake: bus_req is the request valid and bus_addr_ok is its ready.
    // The request fields hold steady from the first bus_req cycle up to and
    // including the bus_addr_ok cycle. bus_data_ok is a one-cycle completion
    // strobe that counts only after (or together with) bus_addr_ok. Only one
    // transaction is outstanding at any time.

    state_t state, state_nxt;

    logic              i_flag_q;
    logic [ADDR_W-1:0] i_addr_q;
    logic [ADDR_W-1:0] d_addr_q;
    logic [STRB_W-1:0] d_wen_q;
    logic [DATA_W-1:0] d_wdata_q;

    logic capture;
    logic d_done;
    logic i_done;

    assign capture   = (state == ST_IDLE) && (inst_en || data_en);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cpu_stall = 1'b1;
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_wstrb = '0;
        bus_addr  = '0;
        bus_wdata = '0;
        d_done    = 1'b0;
        i_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_stall = inst_en || data_en;
                if (data_en) begin
                    state_nxt = ST_D_ADDR;
                end else if (inst_en) begin
                    state_nxt = ST_I_ADDR;
                end
            end
            ST_D_ADDR: begin
                bus_req   = 1'b1;
                bus_wr    = (d_wen_q != '0);
                bus_wstrb = d_wen_q;
                bus_addr  = d_addr_q & ADDR_MASK;
                bus_wdata = d_wdata_q;
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        d_done    = 1'b1;
                        state_nxt = i_flag_q ? ST_I_ADDR : ST_RESP;
                    end else begin
                        state_nxt = ST_D_DATA;
                    end
                end
            end
            ST_D_DATA: begin
                if (bus_data_ok) begin
                    d_done    = 1'b1;
                    state_nxt = i_flag_q ? ST_I_ADDR : ST_RESP;
                end
            end
            ST_I_ADDR: begin
                bus_req  = 1'b1;
                bus_addr = i_addr_q & ADDR_MASK;
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        i_done    = 1'b1;
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_I_DATA;
                    end
                end
            end
            ST_I_DATA: begin
                if (bus_data_ok) begin
                    i_done    = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                cpu_stall = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request bank: snapshot of the pipeline's ports taken when leaving IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_flag_q  <= 1'b0;
            i_addr_q  <= '0;
            d_addr_q  <= '0;
            d_wen_q   <= '0;
            d_wdata_q <= '0;
        end else if (capture) begin
            i_flag_q  <= inst_en;
            i_addr_q  <= inst_addr;
            d_addr_q  <= data_addr;
            d_wen_q   <= data_wen;
            d_wdata_q <= data_wdata;
        end
    end

    // Stores complete without touching data_rdata, so the last load value stays visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_rdata <= '0;
            inst_rdata <= '0;
        end else begin
            if (d_done && (d_wen_q == '0)) begin
                data_rdata <= bus_rdata;
            end
            if (i_done) begin
                inst_rdata <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Directed bench for sram_bus_bridge: a table of hand-computed transactions plus reset sequences.
// A bus responder inside run_txn answers each request with the waits the vector asks for.
module tb_sram_bus_bridge;
    import sram_bus_bridge_pkg::*;

    logic        clk;
    logic        reset;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        data_en;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        cpu_stall;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    state_t      dbg_state;

    sram_bus_bridge dut (
        .clk         (clk),
        .reset       (reset),
        .inst_en     (inst_en),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .data_en     (data_en),
        .data_wen    (data_wen),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .cpu_stall   (cpu_stall),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_wstrb   (bus_wstrb),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // Scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    int cur_vec  = -1;
    // Entry layout: {wr, wstrb[3:0], wdata[31:0], bus_rdata to return[31:0], bus_addr[31:0]}
    logic [100:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got 0x%08h, expected 0x%08h", cur_vec, name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL vec%0d %s: condition not met within bound", cur_vec, name);
    endtask

    typedef struct {
        logic        inst_en;
        logic [31:0] inst_addr;
        logic        data_en;
        logic [3:0]  data_wen;
        logic [31:0] data_addr;
        logic [31:0] data_wdata;
        int          aw;        // bus_req cycles refused before addr_ok
        int          dw;        // cycles from addr_ok to data_ok (0 = same cycle)
        bit          noise;     // addr_ok/data_ok held high in every idle cycle
        logic [31:0] d_bus_rdata;
        logic [31:0] i_bus_rdata;
        logic [31:0] exp_d_bus_addr;
        logic [31:0] exp_i_bus_addr;
        int          exp_stall;
        logic [31:0] exp_data_rdata;
        logic [31:0] exp_inst_rdata;
    } vec_t;

    vec_t vecs[6];

    // Driver
    task automatic run_txn(input vec_t v);
        logic [100:0] cur;
        int  req_cyc = 0;
        int  dcount  = 0;
        int  n_stall = 0;
        int  n_done  = 0;
        int  n_exp;
        bit  waiting = 0;
        bit  done    = 0;
        cur = '0;
        exp_q.delete();
        if (v.data_en)
            exp_q.push_back({(v.data_wen != 4'b0), v.data_wen, v.data_wdata, v.d_bus_rdata, v.exp_d_bus_addr});
        if (v.inst_en)
            exp_q.push_back({1'b0, 4'b0, 32'h0, v.i_bus_rdata, v.exp_i_bus_addr});
        n_exp = exp_q.size();

        @(negedge clk);
        inst_en    = v.inst_en;
        inst_addr  = v.inst_addr;
        data_en    = v.data_en;
        data_wen   = v.data_wen;
        data_addr  = v.data_addr;
        data_wdata = v.data_wdata;
        for (int c = 0; c < 64 && !done; c++) begin
            bus_addr_ok = v.noise;
            bus_data_ok = v.noise;
            bus_rdata   = v.noise ? 32'hFFFF_FFFF : 32'h0;
            #1;
            if (c == 0) check("idle_stall", {31'b0, cpu_stall}, 32'd1);
            if (c > 0 && !cpu_stall) begin
                done = 1;
                check("resp_state", 32'(dbg_state), 32'(ST_RESP));
                check("resp_stall_cycles", n_stall, v.exp_stall);
                check("resp_accesses", n_done, n_exp);
                check("resp_bus_req", {31'b0, bus_req}, 32'd0);
                check("resp_data_rdata", data_rdata, v.exp_data_rdata);
                check("resp_inst_rdata", inst_rdata, v.exp_inst_rdata);
                @(negedge clk);
                #1;
                check("post_resp_state", 32'(dbg_state), 32'(ST_IDLE));
                check("post_resp_data_rdata", data_rdata, v.exp_data_rdata);
                check("post_resp_inst_rdata", inst_rdata, v.exp_inst_rdata);
            end else begin
                n_stall++;
                if (waiting) begin
                    check("req_low_in_data", {31'b0, bus_req}, 32'd0);
                    dcount--;
                    if (dcount == 0) begin
                        bus_data_ok = 1'b1;
                        bus_rdata   = cur[63:32];
                        waiting     = 0;
                        n_done++;
                    end
                end else if (bus_req) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_bus_req");
                        done = 1;
                    end else begin
                        cur = exp_q[0];
                        check("bus_addr", bus_addr, cur[31:0]);
                        check("bus_wr", {31'b0, bus_wr}, {31'b0, cur[100]});
                        check("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, cur[99:96]});
                        if (cur[100]) check("bus_wdata", bus_wdata, cur[95:64]);
                        if (req_cyc == v.aw) begin
                            cur = exp_q.pop_front();
                            bus_addr_ok = 1'b1;
                            req_cyc = 0;
                            if (v.dw == 0) begin
                                bus_data_ok = 1'b1;
                                bus_rdata   = cur[63:32];
                                n_done++;
                            end else begin
                                waiting = 1;
                                dcount  = v.dw;
                            end
                        end else begin
                            bus_addr_ok = 1'b0;
                            req_cyc++;
                        end
                    end
                end
                @(negedge clk);
                inst_en = 1'b0;
                data_en = 1'b0;
            end
        end
        if (!done) fail_now("txn_timeout");
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
    endtask

    initial begin
        reset       = 1'b1;
        inst_en     = 1'b1;
        inst_addr   = 32'h0;
        data_en     = 1'b0;
        data_wen    = 4'b0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;

        //            inst  inst_addr      data wen      data_addr      wdata          aw dw nz d_bus_rdata    i_bus_rdata    exp_d_bus_addr exp_i_bus_addr stall exp_data_rdata exp_inst_rdata
        vecs[0] = '{1'b1, 32'hBFC0_0000, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 0, 2, 0, 32'h0000_0000, 32'h2402_0001, 32'h0000_0000, 32'h1FC0_0000, 4, 32'h0000_0000, 32'h2402_0001};
        vecs[1] = '{1'b1, 32'hBFC0_0004, 1'b1, 4'b0000, 32'h8000_0010, 32'h0000_0000, 1, 1, 0, 32'h1234_5678, 32'h8FA4_0000, 32'h0000_0010, 32'h1FC0_0004, 7, 32'h1234_5678, 32'h8FA4_0000};
        vecs[2] = '{1'b0, 32'h0000_0000, 1'b1, 4'b0001, 32'hA000_0020, 32'h0000_00AB, 0, 1, 0, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0020, 32'h0000_0000, 3, 32'h1234_5678, 32'h8FA4_0000};
        vecs[3] = '{1'b1, 32'hBFC0_0008, 1'b1, 4'b0000, 32'h8000_0100, 32'h0000_0000, 0, 0, 1, 32'hCAFE_0001, 32'h0000_0003, 32'h0000_0100, 32'h1FC0_0008, 3, 32'hCAFE_0001, 32'h0000_0003};
        vecs[4] = '{1'b0, 32'h0000_0000, 1'b1, 4'b0000, 32'h9000_0004, 32'h0000_0000, 0, 0, 1, 32'h5555_AAAA, 32'h0000_0000, 32'h1000_0004, 32'h0000_0000, 2, 32'h5555_AAAA, 32'h0000_0003};
        vecs[5] = '{1'b1, 32'hBFC0_000C, 1'b1, 4'b1111, 32'h8000_0200, 32'h0BAD_F00D, 2, 0, 0, 32'h0000_0000, 32'h1111_2222, 32'h0000_0200, 32'h1FC0_000C, 7, 32'h5555_AAAA, 32'h1111_2222};

        // Reset held with a fetch request pending
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rst_bus_req", {31'b0, bus_req}, 32'd0);
            check("rst_inst_rdata", inst_rdata, 32'h0);
            check("rst_data_rdata", data_rdata, 32'h0);
            check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_stall_comb", {31'b0, cpu_stall}, 32'd1);
        inst_en = 1'b0;
        #1;
        check("idle_stall_clear", {31'b0, cpu_stall}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            cur_vec = i;
            run_txn(vecs[i]);
        end

        // Reset while a load waits in D_DATA; a late data_ok must be dropped
        cur_vec = 6;
        @(negedge clk);
        data_en   = 1'b1;
        data_wen  = 4'b0000;
        data_addr = 32'h8000_0040;
        #1;
        check("mid_rst_idle_stall", {31'b0, cpu_stall}, 32'd1);
        @(negedge clk);
        data_en = 1'b0;
        #1;
        check("mid_rst_d_addr_state", 32'(dbg_state), 32'(ST_D_ADDR));
        check("mid_rst_bus_req", {31'b0, bus_req}, 32'd1);
        check("mid_rst_bus_addr", bus_addr, 32'h0000_0040);
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0;
        #1;
        check("mid_rst_d_data_state", 32'(dbg_state), 32'(ST_D_DATA));
        reset = 1'b1;
        #1;
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("mid_rst_req_low", {31'b0, bus_req}, 32'd0);
        check("mid_rst_data_rdata", data_rdata, 32'h0);
        check("mid_rst_inst_rdata", inst_rdata, 32'h0);
        @(negedge clk);
        reset       = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h7777_7777;
        #1;
        check("late_ok_stall", {31'b0, cpu_stall}, 32'd0);
        check("late_ok_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
        #1;
        check("late_ok_no_resp", 32'(dbg_state), 32'(ST_IDLE));
        check("late_ok_data_rdata", data_rdata, 32'h0);
        check("late_ok_stall_after", {31'b0, cpu_stall}, 32'd0);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
